jogo_memoria_fluxo_dados: RTL and testbench



---
 rtl/jogo_memoria_pkg.sv | 33 +++
 rtl/jogo_memoria_rom_16x4.sv | 12 +
 rtl/jogo_memoria_fluxo_dados.sv | 120 ++++++++++++
 tb/tb_jogo_memoria_fluxo_dados.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/jogo_memoria_pkg.sv
// Shared constants for the memory-game datapath: level limits, timer defaults
// and the fixed one-hot sequence played back to the player.
package jogo_memoria_pkg;

   localparam int ROM_DEPTH = 16;
   localparam int ROM_WIDTH = 4;
   localparam int E_WIDTH   = 5;

   localparam logic [E_WIDTH-1:0]   E_MAX          = 5'd16;
   localparam logic [ROM_WIDTH-1:0] LIMITE_FACIL   = 4'd7;
   localparam logic [ROM_WIDTH-1:0] LIMITE_DIFICIL = 4'd15;

   localparam int TIMEOUT_CYCLES_DEFAULT = 5000;
   localparam int LED_CYCLES_DEFAULT     = 1000;

   typedef enum logic {
      NIVEL_FACIL   = 1'b0,
      NIVEL_DIFICIL = 1'b1
   } nivel_t;

   // Sequence shown to the player, index 0 first
   localparam logic [ROM_WIDTH-1:0] ROM_CONTEUDO [ROM_DEPTH] = '{
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0100, 4'b0010, 4'b0001, 4'b0001,
      4'b0010, 4'b0010, 4'b0100, 4'b0100,
      4'b1000, 4'b1000, 4'b0001, 4'b0100
   };

   function automatic logic [ROM_WIDTH-1:0] limite_nivel(input nivel_t nivel);
      return (nivel == NIVEL_DIFICIL) ? LIMITE_DIFICIL : LIMITE_FACIL;
   endfunction

endpackage

// File: rtl/jogo_memoria_rom_16x4.sv
// Fixed 16x4 sequence ROM with combinational read; the sequence must be
// visible in the same cycle the address counter changes.
module jogo_memoria_rom_16x4
   import jogo_memoria_pkg::*;
(
   input  logic [3:0] endereco,
   output logic [3:0] dado
);

   assign dado = ROM_CONTEUDO[endereco];

endmodule

// File: rtl/jogo_memoria_fluxo_dados.sv
// Memory-game datapath: round/address counters, player register, level,
// shared timer and button-press edge detection, with status flags for the FSM.
module jogo_memoria_fluxo_dados
   import jogo_memoria_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   parameter int LED_CYCLES     = LED_CYCLES_DEFAULT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       zeraE,
   input  logic       contaE,
   input  logic       zeraS,
   input  logic       contaS,
   input  logic       zeraR,
   input  logic       registraR,
   input  logic       contaT,
   input  logic       zeraT,
   input  logic       nivel_uc,
   input  logic [3:0] botoes,
   output logic       fimE,
   output logic       igualE,
   output logic       igualS,
   output logic       maiorS,
   output logic       tem_jogada,
   output logic       timeout,
   output logic       timeoutL,
   output logic [3:0] memoria,
   output logic [3:0] db_contagem,
   output logic [3:0] db_limite,
   output logic [3:0] db_jogada,
   output logic       db_nivel
);

   localparam int T_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [T_WIDTH-1:0] T_MAX = T_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [T_WIDTH-1:0] T_LED = T_WIDTH'(LED_CYCLES - 1);

   logic [E_WIDTH-1:0] e_reg;
   logic [3:0]         s_reg;
   logic [3:0]         r_reg;
   logic [T_WIDTH-1:0] t_reg;
   nivel_t             nivel_reg;
   logic               prev_press_reg;
   logic [3:0]         limite;
   logic [3:0]         rom_dado;

   assign limite = limite_nivel(nivel_reg);

   // E is one bit wider than S so it can step past the last index (16)
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         e_reg <= '0;
      end else if (zeraE) begin
         e_reg <= '0;
      end else if (contaE && (e_reg != E_MAX)) begin
         e_reg <= e_reg + 5'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s_reg     <= '0;
         nivel_reg <= NIVEL_FACIL;
      end else if (zeraS) begin
         s_reg     <= '0;
         nivel_reg <= nivel_t'(nivel_uc);
      end else if (contaS && (s_reg < limite)) begin
         s_reg <= s_reg + 4'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_reg <= '0;
      end else if (zeraR) begin
         r_reg <= '0;
      end else if (registraR) begin
         r_reg <= botoes;
      end
   end

   // Restarting the address counter also restarts the display/reply window
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         t_reg <= '0;
      end else if (zeraT || zeraE) begin
         t_reg <= '0;
      end else if (contaT && (t_reg != T_MAX)) begin
         t_reg <= t_reg + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_press_reg <= 1'b0;
      end else begin
         prev_press_reg <= |botoes;
      end
   end

   jogo_memoria_rom_16x4 u_rom (
      .endereco (e_reg[3:0]),
      .dado     (rom_dado)
   );

   assign fimE        = (e_reg == {1'b0, limite});
   assign igualS      = (e_reg == {1'b0, s_reg});
   assign maiorS      = (e_reg >  {1'b0, s_reg});
   assign igualE      = (r_reg == rom_dado);
   assign tem_jogada  = (|botoes) & ~prev_press_reg;
   assign timeout     = (t_reg == T_MAX);
   assign timeoutL    = (t_reg == T_LED);
   assign memoria     = rom_dado;
   assign db_contagem = e_reg[3:0];
   assign db_limite   = s_reg;
   assign db_jogada   = r_reg;
   assign db_nivel    = (nivel_reg == NIVEL_DIFICIL);

endmodule

// File: tb/tb_jogo_memoria_fluxo_dados.sv
// Bench for the memory-game datapath: directed scenarios then random traffic,
// each cycle's expected outputs queued by the stimulus and checked by a monitor.
module tb_jogo_memoria_fluxo_dados;

   localparam int TO_C  = 8;
   localparam int LED_C = 4;

   logic       clock = 1'b1;
   logic       reset = 1'b1;
   logic       zeraE = 0, contaE = 0, zeraS = 0, contaS = 0, zeraR = 0, registraR = 0;
   logic       contaT = 0, zeraT = 0, nivel_uc = 0;
   logic [3:0] botoes = '0;
   logic       fimE, igualE, igualS, maiorS, tem_jogada, timeout, timeoutL, db_nivel;
   logic [3:0] memoria, db_contagem, db_limite, db_jogada;

   jogo_memoria_fluxo_dados #(.TIMEOUT_CYCLES(TO_C), .LED_CYCLES(LED_C)) dut (
      .clock(clock), .reset(reset), .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS),
      .contaS(contaS), .zeraR(zeraR), .registraR(registraR), .contaT(contaT),
      .zeraT(zeraT), .nivel_uc(nivel_uc), .botoes(botoes), .fimE(fimE),
      .igualE(igualE), .igualS(igualS), .maiorS(maiorS), .tem_jogada(tem_jogada),
      .timeout(timeout), .timeoutL(timeoutL), .memoria(memoria),
      .db_contagem(db_contagem), .db_limite(db_limite), .db_jogada(db_jogada),
      .db_nivel(db_nivel)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic zE, cE, zS, cS, zR, rR, cT, zT, nu;
      logic [3:0] b;
      logic rst;
   } stim_t;

   typedef struct {
      int id;
      bit ige_care;
      logic fim, ige, igs, mai, tem, to, tol, niv;
      logic [3:0] mem, cnt, lim, jog;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Reference model: plain integer state following the game rules
   int rom_pos[16] = '{0, 1, 2, 3, 2, 1, 0, 0, 1, 1, 2, 2, 3, 3, 0, 2};
   int m_e, m_s, m_r, m_t, m_niv, m_prev;

   function automatic int rom_val(int addr);
      return 1 << rom_pos[addr % 16];
   endfunction

   function automatic int lim_of(int niv);
      return niv ? 15 : 7;
   endfunction

   function automatic int min2(int a, int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_reset();
      m_e = 0; m_s = 0; m_r = 0; m_t = 0; m_niv = 0; m_prev = 0;
   endtask

   task automatic model_update(input stim_t st);
      int lim;
      lim = lim_of(m_niv);
      if (st.zE) m_e = 0; else if (st.cE) m_e = min2(m_e + 1, 16);
      if (st.zS) begin m_s = 0; m_niv = int'(st.nu); end
      else if (st.cS) m_s = min2(m_s + 1, lim);
      if (st.zR) m_r = 0; else if (st.rR) m_r = int'(st.b);
      if (st.zT || st.zE) m_t = 0; else if (st.cT) m_t = min2(m_t + 1, TO_C - 1);
      m_prev = (st.b != 0) ? 1 : 0;
   endtask

   task automatic apply(input stim_t st);
      exp_t x;
      zeraE = st.zE; contaE = st.cE; zeraS = st.zS; contaS = st.cS;
      zeraR = st.zR; registraR = st.rR; contaT = st.cT; zeraT = st.zT;
      nivel_uc = st.nu; botoes = st.b; reset = st.rst;
      if (st.rst) model_reset();
      x.id       = cyc;
      x.ige_care = (m_e != 16);
      x.fim = (m_e == lim_of(m_niv));
      x.igs = (m_e == m_s);
      x.mai = (m_e > m_s);
      x.ige = (m_r == rom_val(m_e));
      x.tem = (st.b != 0) && (m_prev == 0);
      x.to  = (m_t == TO_C - 1);
      x.tol = (m_t == LED_C - 1);
      x.niv = (m_niv != 0);
      x.mem = 4'(rom_val(m_e));
      x.cnt = 4'(m_e % 16);
      x.lim = 4'(m_s);
      x.jog = 4'(m_r);
      exp_q.push_back(x);
      @(posedge clock);
      if (!st.rst) model_update(st);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input int id, input logic [3:0] act, input logic [3:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, id, act, req);
      end
   endtask

   // Monitor: outputs are combinational, so every queued cycle is checked mid-cycle
   exp_t mx;
   always @(negedge clock) begin
      while (exp_q.size() != 0) begin
         mx = exp_q.pop_front();
         chk("fimE", mx.id, {3'b0, fimE}, {3'b0, mx.fim});
         chk("igualS", mx.id, {3'b0, igualS}, {3'b0, mx.igs});
         chk("maiorS", mx.id, {3'b0, maiorS}, {3'b0, mx.mai});
         if (mx.ige_care) chk("igualE", mx.id, {3'b0, igualE}, {3'b0, mx.ige});
         chk("tem_jogada", mx.id, {3'b0, tem_jogada}, {3'b0, mx.tem});
         chk("timeout", mx.id, {3'b0, timeout}, {3'b0, mx.to});
         chk("timeoutL", mx.id, {3'b0, timeoutL}, {3'b0, mx.tol});
         chk("db_nivel", mx.id, {3'b0, db_nivel}, {3'b0, mx.niv});
         chk("memoria", mx.id, memoria, mx.mem);
         chk("db_contagem", mx.id, db_contagem, mx.cnt);
         chk("db_limite", mx.id, db_limite, mx.lim);
         chk("db_jogada", mx.id, db_jogada, mx.jog);
         $display("cycle %0d: E=%0d S=%0d R=%0h T-flags=%b%b tem=%b", mx.id,
                  db_contagem, db_limite, db_jogada, timeout, timeoutL, tem_jogada);
      end
   end

   initial begin
      stim_t st;
      model_reset();
      // Reset state
      st = '0; st.rst = 1'b1;
      repeat (2) apply(st);
      // Hard level: S saturates at 15
      st = '0; st.zS = 1; st.nu = 1; apply(st);
      st = '0; st.cS = 1; repeat (20) apply(st);
      // E walks past S to 16 and sticks
      st = '0; st.zE = 1; apply(st);
      st = '0; st.cE = 1; repeat (18) apply(st);
      // Held button gives a single pulse, then register and compare
      st = '0; st.zE = 1; apply(st);
      st = '0; st.b = 4'b0001; repeat (10) apply(st);
      st.rR = 1; apply(st);
      st = '0; apply(st);
      st.cE = 1; apply(st);
      st = '0; apply(st);
      // Second button while first held: no new pulse
      st = '0; st.b = 4'b0010; repeat (2) apply(st);
      st.b = 4'b0110; repeat (2) apply(st);
      st.b = 4'b0000; apply(st);
      // Timer: LED pulse at 3, timeout from 7 on, clear
      st = '0; st.zT = 1; apply(st);
      st = '0; st.cT = 1; repeat (12) apply(st);
      st.zT = 1; apply(st);
      st = '0; repeat (2) apply(st);
      // Easy level: S saturates at 7, fimE at E=7, level held without zeraS
      st = '0; st.zS = 1; st.nu = 0; apply(st);
      st = '0; st.cS = 1; repeat (10) apply(st);
      st = '0; st.zE = 1; apply(st);
      st = '0; st.cE = 1; repeat (8) apply(st);
      st = '0; st.nu = 1; st.cS = 1; repeat (3) apply(st);
      // Mid-game state E=5 S=9 R=0100, clear-vs-count, then async reset
      st = '0; st.zS = 1; st.nu = 1; st.zR = 1; apply(st);
      st = '0; st.cS = 1; repeat (9) apply(st);
      st = '0; st.zE = 1; apply(st);
      st = '0; st.cE = 1; repeat (5) apply(st);
      st = '0; st.zE = 1; st.cE = 1; apply(st);
      st = '0; st.cE = 1; repeat (5) apply(st);
      st = '0; st.b = 4'b0100; st.rR = 1; apply(st);
      st = '0; st.cT = 1; repeat (2) apply(st);
      st = '0; st.rst = 1; apply(st);
      st = '0; st.zE = 1; st.cE = 1; apply(st);
      st = '0; apply(st);
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         st     = '0;
         st.zE  = ($urandom_range(0, 15) == 0);
         st.cE  = ($urandom_range(0, 1) == 0);
         st.zS  = ($urandom_range(0, 31) == 0);
         st.cS  = ($urandom_range(0, 2) == 0);
         st.zR  = ($urandom_range(0, 7) == 0);
         st.rR  = ($urandom_range(0, 3) == 0);
         st.cT  = ($urandom_range(0, 1) == 0);
         st.zT  = ($urandom_range(0, 15) == 0);
         st.nu  = 1'($urandom_range(0, 1));
         st.rst = ($urandom_range(0, 199) == 0);
         case ($urandom_range(0, 5))
            0, 1, 2: st.b = 4'b0000;
            3, 4:    st.b = 4'(1 << $urandom_range(0, 3));
            default: st.b = 4'($urandom_range(0, 15));
         endcase
         apply(st);
      end
      @(negedge clock);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d queued expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
